// File: rtl/id_ex_stage_pkg.sv
// Shared types and constants for the ID/EX operand-select stage.
package id_ex_stage_pkg;

    localparam int unsigned ALU_CTRL_W = 4;

    localparam logic [ALU_CTRL_W-1:0] ALU_AND = 4'b0000;
    localparam logic [ALU_CTRL_W-1:0] ALU_OR  = 4'b0001;
    localparam logic [ALU_CTRL_W-1:0] ALU_ADD = 4'b0010;
    localparam logic [ALU_CTRL_W-1:0] ALU_SUB = 4'b0110;
    localparam logic [ALU_CTRL_W-1:0] ALU_SLT = 4'b0111;

    typedef enum logic [1:0] {
        FWD_REG   = 2'b00,
        FWD_MEMWB = 2'b01,
        FWD_EXMEM = 2'b10
    } fwd_sel_t;

    // Decoded control carried alongside the operands.
    typedef struct packed {
        logic [ALU_CTRL_W-1:0] alu_ctrl;
        logic                  alu_src;
        logic                  reg_dst;
        logic                  reg_write;
        logic                  mem_read;
        logic                  mem_write;
        logic                  mem_to_reg;
    } ex_ctrl_t;

    localparam ex_ctrl_t CTRL_BUBBLE = '{alu_ctrl: ALU_AND, default: 1'b0};

    // EX/MEM is the younger result, so it wins when both sources hit.
    function automatic fwd_sel_t fwd_select(input logic exmem_hit, input logic memwb_hit);
        if (exmem_hit)      return FWD_EXMEM;
        else if (memwb_hit) return FWD_MEMWB;
        else                return FWD_REG;
    endfunction

endpackage

// File: rtl/id_ex_stage_forward_mux.sv
// Per-operand forwarding select between the stage register and later pipeline results.
module forward_mux
    import id_ex_stage_pkg::*;
#(
    parameter int unsigned SIZE  = 32,
    parameter int unsigned RADDR = 5
) (
    input  logic [RADDR-1:0] addr,
    input  logic [SIZE-1:0]  reg_value,
    input  logic             exmem_reg_write,
    input  logic [RADDR-1:0] exmem_rd,
    input  logic [SIZE-1:0]  exmem_result,
    input  logic             memwb_reg_write,
    input  logic [RADDR-1:0] memwb_rd,
    input  logic [SIZE-1:0]  memwb_result,
    output logic [SIZE-1:0]  value
);

    logic     exmem_hit;
    logic     memwb_hit;
    fwd_sel_t sel;

    // $0 is hard-wired to zero, so a write targeting it never forwards.
    assign exmem_hit = exmem_reg_write && (exmem_rd != '0) && (exmem_rd == addr);
    assign memwb_hit = memwb_reg_write && (memwb_rd != '0) && (memwb_rd == addr);
    assign sel       = fwd_select(exmem_hit, memwb_hit);

    always_comb begin
        value = reg_value;
        case (sel)
            FWD_EXMEM: value = exmem_result;
            FWD_MEMWB: value = memwb_result;
            default:   value = reg_value;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding, ALUSrc mux and load-use bubble insertion.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int unsigned SIZE  = 32,
    parameter int unsigned RADDR = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [SIZE-1:0]       id_rs_data,
    input  logic [SIZE-1:0]       id_rt_data,
    input  logic [SIZE-1:0]       id_imm,
    input  logic [RADDR-1:0]      id_rs,
    input  logic [RADDR-1:0]      id_rt,
    input  logic [RADDR-1:0]      id_rd,
    input  logic [ALU_CTRL_W-1:0] id_alu_ctrl,
    input  logic                  id_alu_src,
    input  logic                  id_reg_dst,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  id_mem_write,
    input  logic                  id_mem_to_reg,
    input  logic                  hold,
    input  logic                  flush,
    input  logic                  exmem_reg_write,
    input  logic [RADDR-1:0]      exmem_rd,
    input  logic [SIZE-1:0]       exmem_result,
    input  logic                  memwb_reg_write,
    input  logic [RADDR-1:0]      memwb_rd,
    input  logic [SIZE-1:0]       memwb_result,
    output logic [SIZE-1:0]       alu_in1,
    output logic [SIZE-1:0]       alu_in2,
    output logic [ALU_CTRL_W-1:0] alu_control,
    output logic [SIZE-1:0]       ex_store_data,
    output logic [RADDR-1:0]      ex_write_reg,
    output logic                  ex_reg_write,
    output logic                  ex_mem_read,
    output logic                  ex_mem_write,
    output logic                  ex_mem_to_reg,
    output logic                  load_use
);

    logic [SIZE-1:0]  ex_rs_data;
    logic [SIZE-1:0]  ex_rt_data;
    logic [SIZE-1:0]  ex_imm;
    logic [RADDR-1:0] ex_rs;
    logic [RADDR-1:0] ex_rt;
    logic [RADDR-1:0] ex_rd;
    ex_ctrl_t         ex_ctrl;
    logic [SIZE-1:0]  fwd_rs;
    logic [SIZE-1:0]  fwd_rt;

    assign load_use = ex_ctrl.mem_read && (ex_rt != '0) && ((ex_rt == id_rs) || (ex_rt == id_rt));

    // Hold beats bubble insertion so a stalled instruction is never dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_rs_data <= '0;
            ex_rt_data <= '0;
            ex_imm     <= '0;
            ex_rs      <= '0;
            ex_rt      <= '0;
            ex_rd      <= '0;
            ex_ctrl    <= CTRL_BUBBLE;
        end else if (hold) begin
            ex_rs_data <= ex_rs_data;
            ex_rt_data <= ex_rt_data;
            ex_imm     <= ex_imm;
            ex_rs      <= ex_rs;
            ex_rt      <= ex_rt;
            ex_rd      <= ex_rd;
            ex_ctrl    <= ex_ctrl;
        end else if (flush || load_use) begin
            ex_rs_data <= '0;
            ex_rt_data <= '0;
            ex_imm     <= '0;
            ex_rs      <= '0;
            ex_rt      <= '0;
            ex_rd      <= '0;
            ex_ctrl    <= CTRL_BUBBLE;
        end else begin
            ex_rs_data <= id_rs_data;
            ex_rt_data <= id_rt_data;
            ex_imm     <= id_imm;
            ex_rs      <= id_rs;
            ex_rt      <= id_rt;
            ex_rd      <= id_rd;
            ex_ctrl    <= '{alu_ctrl:   id_alu_ctrl,
                            alu_src:    id_alu_src,
                            reg_dst:    id_reg_dst,
                            reg_write:  id_reg_write,
                            mem_read:   id_mem_read,
                            mem_write:  id_mem_write,
                            mem_to_reg: id_mem_to_reg};
        end
    end

    forward_mux #(.SIZE(SIZE), .RADDR(RADDR)) u_fwd_rs (
        .addr            (ex_rs),
        .reg_value       (ex_rs_data),
        .exmem_reg_write (exmem_reg_write),
        .exmem_rd        (exmem_rd),
        .exmem_result    (exmem_result),
        .memwb_reg_write (memwb_reg_write),
        .memwb_rd        (memwb_rd),
        .memwb_result    (memwb_result),
        .value           (fwd_rs)
    );

    forward_mux #(.SIZE(SIZE), .RADDR(RADDR)) u_fwd_rt (
        .addr            (ex_rt),
        .reg_value       (ex_rt_data),
        .exmem_reg_write (exmem_reg_write),
        .exmem_rd        (exmem_rd),
        .exmem_result    (exmem_result),
        .memwb_reg_write (memwb_reg_write),
        .memwb_rd        (memwb_rd),
        .memwb_result    (memwb_result),
        .value           (fwd_rt)
    );

    assign alu_in1       = fwd_rs;
    assign alu_in2       = ex_ctrl.alu_src ? ex_imm : fwd_rt;
    assign alu_control   = ex_ctrl.alu_ctrl;
    assign ex_store_data = fwd_rt;
    assign ex_write_reg  = ex_ctrl.reg_dst ? ex_rd : ex_rt;
    assign ex_reg_write  = ex_ctrl.reg_write;
    assign ex_mem_read   = ex_ctrl.mem_read;
    assign ex_mem_write  = ex_ctrl.mem_write;
    assign ex_mem_to_reg = ex_ctrl.mem_to_reg;

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register and operand-select stage of the pipelined MIPS datapath; sits directly upstream of the shared ALU and drives its in1, in2 and 4-bit control.
- Captures decoded operands and control from ID each cycle.
- Resolves EX/MEM and MEM/WB forwarding and the ALUSrc immediate mux.
- Detects load-use hazards and inserts a bubble itself.

Parameters:
- SIZE, 32, datapath width; matches the ALU size parameter.
- RADDR, 5, register-file address width.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- id_rs_data  in  SIZE  register-file read port 1
- id_rt_data  in  SIZE  register-file read port 2
- id_imm  in  SIZE  sign-extended immediate
- id_rs, id_rt, id_rd  in  RADDR  register specifiers
- id_alu_ctrl  in  4  ALU operation: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT
- id_alu_src, id_reg_dst, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg  in  1  decoded control bits
- hold  in  1  freeze stage contents (downstream stall)
- flush  in  1  squash the instruction entering (taken branch/jump)
- exmem_reg_write  in  1  EX/MEM forwarding source write enable
- exmem_rd  in  RADDR  EX/MEM forwarding source destination
- exmem_result  in  SIZE  EX/MEM forwarding source value
- memwb_reg_write  in  1  MEM/WB forwarding source write enable
- memwb_rd  in  RADDR  MEM/WB forwarding source destination
- memwb_result  in  SIZE  MEM/WB forwarding source value
- alu_in1, alu_in2  out  SIZE  ALU operands
- alu_control  out  4  ALU operation
- ex_store_data  out  SIZE  forwarded rt value for sw
- ex_write_reg  out  RADDR  destination (rd if reg_dst else rt)
- ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg  out  1  control passed to EX/MEM
- load_use  out  1  load-use hazard; hazard unit uses it to stall PC and IF/ID

Behaviour:
- Reset (async, rst_n=0):
  - All registered fields clear.
  - Outputs are 0; alu_control=0000.
  - Stage holds a bubble.
- Register update on clk rising edge, priority highest first:
  - hold: keep all contents.
  - flush or load_use: load bubble (all control bits 0, alu_ctrl 0000, registers 0, data 0).
  - otherwise: capture all id_* inputs.
- hold=1 together with flush or load_use: hold wins; the held instruction is never lost.
- Latency: ID inputs appear on the ALU outputs one cycle after capture. Forwarding and muxes are combinational on registered values.
- Forwarding, applied to rs and rt independently:
  - If exmem_reg_write and exmem_rd != 0 and exmem_rd == reg: select exmem_result.
  - Else if memwb_reg_write and memwb_rd != 0 and memwb_rd == reg: select memwb_result.
  - Else: select the registered value.
  - EX/MEM has priority when both sources match.
  - $0 is never forwarded.
- alu_in1 = forwarded rs.
- alu_in2 = id_imm (registered) if alu_src, else forwarded rt.
- ex_store_data = forwarded rt, regardless of alu_src.
- ex_write_reg = registered rd if reg_dst, else registered rt.
- load_use (combinational) = ex_mem_read && ex_rt != 0 && (ex_rt == id_rs || ex_rt == id_rt).
- A bubble is one-cycle idle: it writes nothing and cannot match a forwarding source.
- Reset asserted mid-operation discards the in-flight instruction immediately, asynchronously.

Decomposition:
- Shared package holds:
  - ALU opcode constants: ALU_AND 0000, ALU_OR 0001, ALU_ADD 0010, ALU_SUB 0110, ALU_SLT 0111.
  - Forward-select encoding: FWD_REG 00, FWD_MEMWB 01, FWD_EXMEM 10.
- One natural sub-module, forward_mux:
  - Combinational; one per operand; instantiated twice (rs, rt).
  - Inputs: reg address, registered value, both forwarding sources.
  - Output: forwarded value.

Test Plan:
- Reset/capture: rst_n=0 → all outputs 0. Release rst_n, present rs_data=21, rt_data=12, alu_ctrl=0010, alu_src=0 → next cycle alu_in1=21, alu_in2=12, alu_control=0010.
- Immediate select: id_imm=0xFFFFFFFC with alu_src=1, alu_ctrl=0010 → alu_in2=0xFFFFFFFC; ex_store_data still equals rt_data.
- Forward priority: captured rs=5; exmem_rd=5, exmem_result=100; memwb_rd=5, memwb_result=200; both write enables=1 → alu_in1=100. Drop exmem_reg_write → alu_in1=200. Set both rd=0 → registered value.
- Load-use: stage holds lw with rt=8 (mem_read=1); id_rs=8 → load_use=1; next cycle all ex_* control=0. Same with id_rt=0 and ex_rt=0 → load_use=0.
- Flush vs hold: flush=1 → next cycle bubble. hold=1 and flush=1 together → contents unchanged for 3 held cycles.
- Async reset mid-stream: drop rst_n between clock edges during a valid sub → outputs go to 0 before the next edge.
